// File: rtl/cordic_sincos.sv
// Iterative CORDIC sine/cosine generator.
// An 11-bit phase code (1024 codes per turn, a[10] ignored) becomes signed 13-bit cos/sin values
// scaled so that 2048 represents 1.0. One iteration runs per enabled cycle. Results are latched and
// flagged with a one-cycle vld pulse.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous reset, active-high despite the legacy name
//   clk_vld      clock enable; when low, all state holds
//   soft_rst     synchronous reset, honoured on every clk edge even when clk_vld is low
//   trig         start pulse, accepted only in idle
//   a            phase code, angle = a[9:0] * 2*pi / 1024
//   vld          one-cycle pulse: new results on the latched outputs
//   cosa3_latch  signed cos * 2048, held until the next result
//   sina3_latch  signed sin * 2048, held until the next result
module cordic_sincos (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_vld,
  input  logic               soft_rst,
  input  logic               trig,
  input  logic [10:0]        a,
  output logic               vld,
  output logic signed [12:0] cosa3_latch,
  output logic signed [12:0] sina3_latch
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // Initial x is the CORDIC gain compensation 0.6072529 * 2^15.
  localparam logic signed [17:0] XInit    = 18'sd19898;
  localparam logic        [3:0]  LastIter = 4'd13;

  logic        [1:0]  state_q, state_d;
  logic        [3:0]  iter_q,  iter_d;
  logic        [1:0]  quad_q,  quad_d;
  logic signed [17:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic               vld_q,   vld_d;
  logic signed [12:0] cos_q,   cos_d, sin_q, sin_d;

  logic signed [17:0] atan_val;
  logic signed [17:0] x_shift, y_shift;
  logic        [21:0] z_prod;
  logic signed [17:0] z_init;
  logic signed [17:0] x_rnd, y_rnd;
  logic signed [12:0] c_val, s_val;

  // round(atan(2^-i) * 2^15)
  always_comb begin
    atan_val = 18'sd0;
    case (iter_q)
      4'd0:    atan_val = 18'sd25736;
      4'd1:    atan_val = 18'sd15193;
      4'd2:    atan_val = 18'sd8027;
      4'd3:    atan_val = 18'sd4075;
      4'd4:    atan_val = 18'sd2045;
      4'd5:    atan_val = 18'sd1024;
      4'd6:    atan_val = 18'sd512;
      4'd7:    atan_val = 18'sd256;
      4'd8:    atan_val = 18'sd128;
      4'd9:    atan_val = 18'sd64;
      4'd10:   atan_val = 18'sd32;
      4'd11:   atan_val = 18'sd16;
      4'd12:   atan_val = 18'sd8;
      4'd13:   atan_val = 18'sd4;
      default: atan_val = 18'sd0;
    endcase
  end

  function automatic logic signed [12:0] clamp_2048(input logic signed [17:0] v);
    logic signed [12:0] r;
    if (v > 18'sd2048) begin
      r = 13'sd2048;
    end else if (v < -18'sd2048) begin
      r = -13'sd2048;
    end else begin
      r = v[12:0];
    end
    return r;
  endfunction

  assign x_shift = x_q >>> iter_q;
  assign y_shift = y_q >>> iter_q;

  // Angle within the quadrant in radians * 2^15: a[7:0] * (2*pi/1024) * 2^15 = a * 12868 / 64.
  assign z_prod = {14'd0, a[7:0]} * 22'd12868;
  assign z_init = signed'({2'b00, z_prod[21:6]});

  // Divide by 16 with round-half-up.
  assign x_rnd = (x_q + 18'sd8) >>> 4;
  assign y_rnd = (y_q + 18'sd8) >>> 4;
  assign c_val = clamp_2048(x_rnd);
  assign s_val = clamp_2048(y_rnd);

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    quad_d  = quad_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    vld_d   = 1'b0;
    cos_d   = cos_q;
    sin_d   = sin_q;
    case (state_q)
      StIdle: begin
        if (trig) begin
          quad_d  = a[9:8];
          x_d     = XInit;
          y_d     = 18'sd0;
          z_d     = z_init;
          iter_d  = 4'd0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (z_q >= 18'sd0) begin
          x_d = x_q - y_shift;
          y_d = y_q + x_shift;
          z_d = z_q - atan_val;
        end else begin
          x_d = x_q + y_shift;
          y_d = y_q - x_shift;
          z_d = z_q + atan_val;
        end
        iter_d = iter_q + 4'd1;
        if (iter_q == LastIter) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // Rotate the first-quadrant result into the quadrant selected by a[9:8].
        case (quad_q)
          2'd0:    begin cos_d = c_val;  sin_d = s_val;  end
          2'd1:    begin cos_d = -s_val; sin_d = c_val;  end
          2'd2:    begin cos_d = -c_val; sin_d = -s_val; end
          default: begin cos_d = s_val;  sin_d = -c_val; end
        endcase
        vld_d   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= StIdle;
      iter_q  <= 4'd0;
      quad_q  <= 2'd0;
      x_q     <= 18'sd0;
      y_q     <= 18'sd0;
      z_q     <= 18'sd0;
      vld_q   <= 1'b0;
      cos_q   <= 13'sd0;
      sin_q   <= 13'sd0;
    end else if (soft_rst) begin
      state_q <= StIdle;
      iter_q  <= 4'd0;
      quad_q  <= 2'd0;
      x_q     <= 18'sd0;
      y_q     <= 18'sd0;
      z_q     <= 18'sd0;
      vld_q   <= 1'b0;
      cos_q   <= 13'sd0;
      sin_q   <= 13'sd0;
    end else if (clk_vld) begin
      state_q <= state_d;
      iter_q  <= iter_d;
      quad_q  <= quad_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      vld_q   <= vld_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
    end
  end

  assign vld         = vld_q;
  assign cosa3_latch = cos_q;
  assign sina3_latch = sin_q;

endmodule

// File: tb/tb_cordic_sincos.sv
module tb_cordic_sincos;

  logic               clk;
  logic               rst_n;
  logic               clk_vld;
  logic               soft_rst;
  logic               trig;
  logic [10:0]        a;
  logic               vld;
  logic signed [12:0] cosa3_latch;
  logic signed [12:0] sina3_latch;

  cordic_sincos dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_vld     (clk_vld),
    .soft_rst    (soft_rst),
    .trig        (trig),
    .a           (a),
    .vld         (vld),
    .cosa3_latch (cosa3_latch),
    .sina3_latch (sina3_latch)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected values are in LSB * 256 so real-valued references keep sub-LSB precision.
  typedef struct {
    int av;
    int c;
    int s;
    int tol;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic vld_prev = 1'b0;

  task automatic cmp(input string nm, input int av, input int act, input int exp_x256,
                     input int tol_x256);
    int d;
    n_vec++;
    d = act * 256 - exp_x256;
    if (d < 0) d = -d;
    if (d > tol_x256) begin
      n_err++;
      $display("FAIL %s a=%0d got %0d want %0.2f (tol %0.2f)", nm, av, act,
               real'(exp_x256) / 256.0, real'(tol_x256) / 256.0);
    end
  endtask

  // Monitor: pop one expectation on each rising vld.
  always @(negedge clk) begin
    if (vld && !vld_prev) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_vld got vld=1 want no result pending");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        cmp("cos", e.av, int'(cosa3_latch), e.c, e.tol);
        cmp("sin", e.av, int'(sina3_latch), e.s, e.tol);
      end
    end
    vld_prev <= vld;
  end

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  // Start one operation, optionally stall or re-trigger mid-run, and check the vld timing.
  task automatic run_op(input int av, input int ec, input int es, input int tol,
                        input int stall_at, input int retrig_at, input int exp_lat);
    exp_t e;
    int   lat;
    bit   got;
    @(negedge clk);
    a    = av[10:0];
    trig = 1'b1;
    e.av = av; e.c = ec; e.s = es; e.tol = tol;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    trig = 1'b0;
    lat  = 0;
    got  = 1'b0;
    while (lat < 100 && !got) begin
      clk_vld = !(stall_at >= 0 && lat >= stall_at && lat < stall_at + 5);
      if (lat == retrig_at) begin
        trig = 1'b1;
        a    = 11'd512;
      end else begin
        trig = 1'b0;
      end
      @(posedge clk);
      lat++;
      #1;
      if (vld) got = 1'b1;
      else @(negedge clk);
    end
    cmp("latency", av, lat, exp_lat * 256, 0);
    @(negedge clk);
    trig    = 1'b0;
    clk_vld = 1'b1;
    @(posedge clk);
    #1;
    cmp("vld_pulse", av, int'(vld), 0, 0);
  endtask

  initial begin
    int cnt;
    rst_n    = 1'b1;
    clk_vld  = 1'b1;
    soft_rst = 1'b0;
    trig     = 1'b0;
    a        = 11'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    cmp("rst_vld", 0, int'(vld), 0, 0);
    cmp("rst_cos", 0, int'(cosa3_latch), 0, 0);
    cmp("rst_sin", 0, int'(sina3_latch), 0, 0);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (vld) cnt++;
    end
    cmp("idle_no_vld", 0, cnt, 0, 0);

    // Cardinal and diagonal angles
    run_op(0,    2048 * 256,  0,           3 * 256, -1, -1, 15);
    run_op(256,  0,           2048 * 256,  3 * 256, -1, -1, 15);
    run_op(512,  -2048 * 256, 0,           3 * 256, -1, -1, 15);
    run_op(768,  0,           -2048 * 256, 3 * 256, -1, -1, 15);
    run_op(128,  1448 * 256,  1448 * 256,  3 * 256, -1, -1, 15);
    run_op(384,  -1448 * 256, 1448 * 256,  3 * 256, -1, -1, 15);
    run_op(1152, 1448 * 256,  1448 * 256,  3 * 256, -1, -1, 15);

    // Re-trigger with a different phase mid-run is ignored
    run_op(0,    2048 * 256,  0,           3 * 256, -1, 5, 15);
    // Five-cycle enable drop mid-run delays vld by five cycles
    run_op(128,  1448 * 256,  1448 * 256,  3 * 256, 5, -1, 20);

    // soft_rst on the edge where iteration 7 would run aborts the operation
    @(negedge clk);
    a    = 11'd256;
    trig = 1'b1;
    @(posedge clk);
    @(negedge clk);
    trig = 1'b0;
    repeat (7) @(negedge clk);
    soft_rst = 1'b1;
    @(negedge clk);
    soft_rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (vld) cnt++;
    end
    cmp("softrst_no_vld", 256, cnt, 0, 0);
    cmp("softrst_cos", 256, int'(cosa3_latch), 0, 0);
    cmp("softrst_sin", 256, int'(sina3_latch), 0, 0);
    run_op(64, 1892 * 256, 784 * 256, 3 * 256, -1, -1, 15);

    // Full sweep against the real-valued reference
    for (int av = 0; av < 1024; av++) begin
      real ang;
      ang = real'(av) * 0.0061359232;
      run_op(av, rnd($cos(ang) * 2048.0 * 256.0), rnd($sin(ang) * 2048.0 * 256.0), 3 * 256,
             -1, -1, 15);
    end

    repeat (5) @(negedge clk);
    cmp("queue_drained", 0, exp_q.size(), 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
